// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero detector and its normalizer.
//   LZD_WIDTH : operand width
//   LZD_CNT_W : count width, clog2(LZD_WIDTH)+1 so a full-width count fits
//   LZD_EXP_W : unsigned exponent width carried alongside the operand
//   lzd_state_t : normalizer FSM encoding
package lzd_pkg;
    localparam int LZD_WIDTH = 64;
    localparam int LZD_CNT_W = 7;
    localparam int LZD_EXP_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } lzd_state_t;
endpackage

// File: rtl/lzd_normalizer.sv
// Iterative normalizer: shifts the operand left by the detector's count so
// the MSB becomes 1, and subtracts the count from the exponent. One count
// bit (MSB first) is resolved per cycle.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   start                     : request, sampled only in IDLE
//   data_in/count_in/         : operand, detector count, detector zero flag,
//   all_zero_in/exp_in          exponent; all captured on acceptance
//   data_out/exp_out          : normalized operand / adjusted exponent
//   zero/underflow/norm_err   : result flags, held until the next result
//   busy/done                 : busy in SHIFT and DONE, done pulses in DONE
module lzd_normalizer
    import lzd_pkg::*;
#(
    parameter int WIDTH = LZD_WIDTH,
    parameter int CNT_W = LZD_CNT_W,
    parameter int EXP_W = LZD_EXP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] count_in,
    input  logic             all_zero_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic [WIDTH-1:0] data_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             zero,
    output logic             underflow,
    output logic             norm_err,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = $clog2(CNT_W);

    lzd_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [EXP_W-1:0] r_exp;
    logic [IDX_W-1:0] r_idx;

    logic [CNT_W-1:0] w_amt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_uf;
    logic             w_last;

    // Shift amount for this step is 2^idx; the top step (64) clears the
    // operand entirely, which is what a saturated count asks for.
    assign w_amt     = CNT_W'(1) << r_idx;
    assign w_shifted = r_cnt[r_idx] ? (r_data << w_amt) : r_data;
    assign w_uf      = EXP_W'(r_cnt) > r_exp;
    assign w_last    = (r_idx == '0);

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = all_zero_in ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_idx     <= '0;
            data_out  <= '0;
            exp_out   <= '0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            norm_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_data <= data_in;
                    r_cnt  <= (count_in > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count_in;
                    r_exp  <= exp_in;
                    r_idx  <= IDX_W'(CNT_W - 1);
                    // Detector says zero: skip shifting and publish now.
                    if (all_zero_in) begin
                        data_out  <= '0;
                        exp_out   <= '0;
                        zero      <= 1'b1;
                        underflow <= 1'b0;
                        norm_err  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_shifted;
                    r_idx  <= r_idx - IDX_W'(1);
                    if (w_last) begin
                        data_out  <= w_shifted;
                        exp_out   <= w_uf ? '0 : (r_exp - EXP_W'(r_cnt));
                        underflow <= w_uf;
                        zero      <= (w_shifted == '0);
                        // Count disagreed with the operand: MSB still clear.
                        norm_err  <= (w_shifted != '0) && !w_shifted[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/lzd_normalizer.md
Name: lzd_normalizer

Overview:
- Downstream stage of the multi-cycle leading zero detector.
- Consumes the detector's count and all_zero results, left-shifts the 64-bit operand so its MSB is 1, and adjusts an accompanying exponent by the count.
- Iterative: one count bit is resolved per cycle (MSB first), using a start/busy/done handshake that matches the detector's.
- Output feeds the rounding/packing stage of the arithmetic datapath.

Parameters:
- WIDTH, 64, operand width.
- CNT_W, 7, count width; must equal clog2(WIDTH)+1.
- EXP_W, 11, exponent width, unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- data_in  input  WIDTH  operand, as presented to the detector
- count_in  input  CNT_W  leading-zero count from the detector
- all_zero_in  input  1  zero flag from the detector
- exp_in  input  EXP_W  exponent associated with data_in
- data_out  output  WIDTH  normalized operand
- exp_out  output  EXP_W  adjusted exponent
- zero  output  1  result is zero
- underflow  output  1  count_in > exp_in
- norm_err  output  1  nonzero result whose MSB is 0 (inconsistent count)
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Reset mid-operation aborts immediately. No done is produced, and outputs return to 0.
- FSM states:
  - IDLE -> SHIFT on start=1 with all_zero_in=0.
  - IDLE -> DONE on start=1 with all_zero_in=1.
  - SHIFT -> DONE after bit index 0 has been processed.
  - DONE -> IDLE unconditionally.
- Capture, at the edge where start is accepted (E0):
  - data_reg <= data_in.
  - cnt_reg <= min(count_in, WIDTH); values above WIDTH saturate to WIDTH.
  - exp_reg <= exp_in.
  - idx <= CNT_W-1.
- SHIFT, on each edge:
  - If cnt_reg[idx]=1, data_reg <= data_reg << 2^idx. Bits shifted out are lost; zeros fill from the LSB.
  - idx decrements.
  - Exactly CNT_W edges are spent in SHIFT (E1..E7 for the defaults).
- Exponent, computed at the transition into DONE:
  - If cnt_reg <= exp_reg: exp_out = exp_reg - cnt_reg, underflow=0.
  - Otherwise: exp_out = 0, underflow=1.
- Flags, computed at the transition into DONE:
  - zero = all_zero captured, or data_reg==0 after shifting.
  - norm_err = (zero==0) and data_out[WIDTH-1]==0.
- All-zero path: data_out=0, exp_out=0, zero=1, underflow=0, norm_err=0.
- Latency:
  - Normal path: done is high in the cycle after E(CNT_W), i.e. 8 cycles after start is sampled.
  - All-zero path: done is high in the cycle after E0.
- busy is high in SHIFT and DONE, low in IDLE.
- done is high only in DONE, for exactly one cycle.
- Result hold: data_out, exp_out, zero, underflow and norm_err are held from DONE until the next accepted start. They do not change while IDLE.
- start while busy=1 is ignored; it is not queued.
- start held high continuously: a new operation is accepted on the first IDLE edge. This gives back-to-back operations with one IDLE cycle between them.
- Inputs are only sampled at E0. Changes after E0 have no effect on the operation in progress.

Decomposition:
- Shared package lzd_pkg:
  - WIDTH and CNT_W defaults (shared with the detector).
  - EXP_W default.
  - FSM state encoding (IDLE, SHIFT, DONE).
- No sub-module. The conditional shift-by-2^idx is a single registered mux in this module.

Test Plan:
- data_in=64'h1, count_in=63, exp_in=100 -> data_out=64'h8000_0000_0000_0000, exp_out=37, underflow=0, zero=0, norm_err=0; done 8 cycles after start, busy high for 8 cycles.
- data_in=64'h8000_0000_0000_0000, count_in=0, exp_in=5 -> data_out unchanged, exp_out=5; latency 8 cycles.
- all_zero_in=1, count_in=64, data_in=0, exp_in=20 -> zero=1, data_out=0, exp_out=0; done 1 cycle after start.
- data_in=64'h0000_0000_0F00_0000, count_in=36, exp_in=3 -> data_out=64'hF000_0000_0000_0000, underflow=1, exp_out=0.
- data_in=64'h1, count_in=10 (inconsistent) -> data_out=64'h400, norm_err=1.
- Robustness, from a single operation with data_in=64'h1, count_in=63:
  - Pulse start again at cycle 3 -> ignored; result matches the single-operation result.
  - Assert rst_n=0 at cycle 4 -> all outputs 0 immediately, no done pulse.
  - Then a fresh start -> correct result.
